// File: rtl/lfsr_aging_arbiter.sv
// Random-priority N-way arbiter: an 8-bit LFSR picks the scan start, and per-requester aging forces starved grants.
// Optional ARB_LOCK_EN adds a lock input that freezes the hold countdown while the holder keeps requesting.
module lfsr_aging_arbiter #(
    parameter int unsigned NUM_REQS   = 4,
    parameter int unsigned GRANT_HOLD = 4,
    parameter int unsigned MAX_WAIT   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          lfsr_seed,
    input  logic                seed_load,
    input  logic [NUM_REQS-1:0] req,
`ifdef ARB_LOCK_EN
    input  logic                lock,
`endif
    output logic [NUM_REQS-1:0] grant,
    output logic                grant_valid,
    output logic                starve_grant,
    output logic [7:0]          lfsr_state
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = $clog2(NUM_REQS);
    localparam int unsigned HOLD_W = (GRANT_HOLD > 1) ? $clog2(GRANT_HOLD) : 1;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e              state_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [CNT_W-1:0]    wait_q [NUM_REQS];
    logic [CNT_W-1:0]    wait_d [NUM_REQS];
    logic [7:0]          lfsr_q, lfsr_d, seed_map;
    logic [NUM_REQS-1:0] grant_q, sel_d;
    logic                grant_valid_q, starve_q, starve_d;
    logic                lock_w, holder_req, arb, found;
    int unsigned         start, idx;

`ifdef ARB_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    assign seed_map   = (lfsr_seed == 8'h00) ? 8'h01 : lfsr_seed;
    assign lfsr_d     = seed_load ? seed_map
                                  : {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign holder_req = |(req & grant_q);
    // A locked holder with its req still high never reaches a decision point.
    assign arb        = (state_q == IDLE) || !holder_req || ((hold_cnt_q == '0) && !lock_w);

    // Aging winner first (lowest index), otherwise LFSR-seeded round scan.
    always_comb begin
        sel_d    = '0;
        starve_d = 1'b0;
        found    = 1'b0;
        start    = 32'(lfsr_q[2:0]) % NUM_REQS;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (!found && req[IDX_W'(i)] && (wait_q[IDX_W'(i)] >= CNT_W'(MAX_WAIT))) begin
                sel_d[IDX_W'(i)] = 1'b1;
                starve_d         = 1'b1;
                found            = 1'b1;
            end
        end
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            idx = (start + k) % NUM_REQS;
            if (!found && req[IDX_W'(idx)]) begin
                sel_d[IDX_W'(idx)] = 1'b1;
                found              = 1'b1;
            end
        end
    end

    // Wait counters count cycles spent requesting without holding the grant.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (!req[IDX_W'(i)] || grant_q[IDX_W'(i)]) begin
                wait_d[IDX_W'(i)] = '0;
            end else if (wait_q[IDX_W'(i)] != {CNT_W{1'b1}}) begin
                wait_d[IDX_W'(i)] = wait_q[IDX_W'(i)] + CNT_W'(1);
            end else begin
                wait_d[IDX_W'(i)] = wait_q[IDX_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            wait_q        <= '{default: '0};
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            starve_q      <= 1'b0;
            lfsr_q        <= seed_map;
        end else begin
            lfsr_q <= lfsr_d;
            wait_q <= wait_d;
            if (arb) begin
                grant_q       <= sel_d;
                grant_valid_q <= |sel_d;
                starve_q      <= starve_d;
                if (|sel_d) begin
                    state_q    <= HOLD;
                    hold_cnt_q <= HOLD_W'(GRANT_HOLD - 1);
                end else begin
                    state_q    <= IDLE;
                    hold_cnt_q <= '0;
                end
            end else if (!lock_w) begin
                hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            end
        end
    end

    assign grant        = grant_q;
    assign grant_valid  = grant_valid_q;
    assign starve_grant = starve_q;
    assign lfsr_state   = lfsr_q;

endmodule

// File: tb/tb_lfsr_aging_arbiter.sv
// Scoreboard bench for lfsr_aging_arbiter: a behavioural model queues expected outputs per edge.
module tb_lfsr_aging_arbiter;

    localparam int NR = 4;
    localparam int GH = 4;
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    lfsr_seed;
    logic          seed_load;
    logic [NR-1:0] req;
    logic          lock;
    logic [NR-1:0] grant;
    logic          grant_valid, starve_grant;
    logic [7:0]    lfsr_state;

    always #5 clk = ~clk;

    lfsr_aging_arbiter #(.NUM_REQS(NR), .GRANT_HOLD(GH), .MAX_WAIT(MW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lfsr_seed    (lfsr_seed),
        .seed_load    (seed_load),
        .req          (req),
`ifdef ARB_LOCK_EN
        .lock         (lock),
`endif
        .grant        (grant),
        .grant_valid  (grant_valid),
        .starve_grant (starve_grant),
        .lfsr_state   (lfsr_state)
    );

    typedef struct packed {
        logic [NR-1:0] g;
        logic          s;
        logic [7:0]    l;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [NR-1:0] m_grant;
    logic          m_starve;
    logic [7:0]    m_lfsr;
    int            m_age;
    int            m_wait [NR];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: advances one clock edge from the inputs currently driven.
    task automatic model_step();
        logic [NR-1:0] nxt;
        logic          nst;
        logic          decide;
        logic          lk;
        int            st, j;
        int            nw [NR];
        exp_t          e;
`ifdef ARB_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        if (!rst_n) begin
            m_grant  = '0;
            m_starve = 1'b0;
            m_age    = 0;
            m_lfsr   = (lfsr_seed == 8'h00) ? 8'h01 : lfsr_seed;
            for (int i = 0; i < NR; i++) m_wait[i] = 0;
        end else begin
            decide = (m_grant == '0) || ((req & m_grant) == '0) || ((m_age >= GH) && !lk);
            for (int i = 0; i < NR; i++)
                nw[i] = (req[i] && !m_grant[i]) ? ((m_wait[i] >= 255) ? 255 : m_wait[i] + 1) : 0;
            if (decide) begin
                nxt = '0;
                nst = 1'b0;
                for (int i = 0; i < NR; i++)
                    if (nxt == '0 && req[i] && m_wait[i] >= MW) begin
                        nxt[i] = 1'b1;
                        nst    = 1'b1;
                    end
                if (nxt == '0) begin
                    st = int'(m_lfsr & 8'h03);
                    for (int k = 0; k < NR; k++) begin
                        j = (st + k) % NR;
                        if (nxt == '0 && req[j]) nxt[j] = 1'b1;
                    end
                end
                m_grant  = nxt;
                m_starve = nst;
                m_age    = 1;
            end else if (!lk) begin
                m_age = m_age + 1;
            end
            if (seed_load) m_lfsr = (lfsr_seed == 8'h00) ? 8'h01 : lfsr_seed;
            else           m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            for (int i = 0; i < NR; i++) m_wait[i] = nw[i];
        end
        e.g = m_grant;
        e.s = m_starve;
        e.l = m_lfsr;
        sb_q.push_back(e);
    endtask

    // Predict, clock, then compare the DUT against the oldest queued expectation.
    task automatic step();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("grant", 32'(grant), 32'(e.g));
            check_eq("grant_valid", 32'(grant_valid), 32'(|e.g));
            check_eq("starve_grant", 32'(starve_grant), 32'(e.s));
            check_eq("lfsr_state", 32'(lfsr_state), 32'(e.l));
        end
    endtask

    logic [NR-1:0] seen, old_g;
    logic          hit;

    initial begin
        rst_n = 1'b0; lfsr_seed = 8'h00; seed_load = 1'b0; req = '0; lock = 1'b0;

        // T1: zero seed maps to 01, single requester granted right after release
        step(); step();
        check_eq("t1_rst_lfsr", 32'(lfsr_state), 32'h01);
        check_eq("t1_rst_grant", 32'(grant), 32'h0);
        check_eq("t1_rst_starve", 32'(starve_grant), 32'h0);
        rst_n = 1'b1; req = 4'b0001;
        for (int c = 0; c < GH; c++) begin
            step();
            check_eq("t1_hold", 32'(grant), 32'h1);
        end

        // T2: all requesting from seed A5
        rst_n = 1'b0; lfsr_seed = 8'hA5; req = 4'b1111;
        step();
        rst_n = 1'b1;
        seen = '0; hit = 1'b1;
        for (int c = 0; c < 64; c++) begin
            step();
            seen = seen | grant;
            if (!grant_valid) hit = 1'b0;
            if (c == 39) check_eq("t2_all_served", 32'(seen), 32'hF);
        end
        check_eq("t2_no_gap", 32'(hit), 32'h1);

        // T3: pin LFSR so req1 always wins the random scan; req0 must age through
        req = 4'b0011; lfsr_seed = 8'h01; seed_load = 1'b1; hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            step();
            if (grant == 4'b0001 && starve_grant) hit = 1'b1;
        end
        check_eq("t3_starve_grant", 32'(hit), 32'h1);
        seed_load = 1'b0;

        // T4: holder drops req at hold cycle 2
        req = 4'b1111; old_g = grant;
        for (int c = 0; c < 8 && grant == old_g; c++) step();
        step();
        old_g = grant;
        req = 4'b1111 & ~old_g;
        step();
        check_eq("t4_moved", 32'(grant != old_g), 32'h1);
        req = old_g;
        for (int c = 0; c < 8 && grant != old_g; c++) step();
        step();
        req = '0;
        step();
        check_eq("t4_drop_idle", 32'(grant), 32'h0);

        // T5: reset while holding 0100
        req = 4'b0100;
        for (int c = 0; c < 8 && grant != 4'b0100; c++) step();
        check_eq("t5_held", 32'(grant), 32'h4);
        rst_n = 1'b0;
        step();
        check_eq("t5_rst_grant", 32'(grant), 32'h0);
        check_eq("t5_rst_starve", 32'(starve_grant), 32'h0);
        rst_n = 1'b1;
        step();
        check_eq("t5_regrant", 32'(grant), 32'h4);

`ifdef ARB_LOCK_EN
        // T6: lock holds req0's grant while req1 ages
        rst_n = 1'b0; lfsr_seed = 8'h04; req = 4'b0011;
        step();
        rst_n = 1'b1;
        step();
        check_eq("t6_first", 32'(grant), 32'h1);
        lock = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            check_eq("t6_locked", 32'(grant), 32'h1);
        end
        lock = 1'b0;
        for (int c = 0; c < 8 && grant == 4'b0001; c++) step();
        check_eq("t6_next", 32'(grant), 32'h2);
        check_eq("t6_starve", 32'(starve_grant), 32'h1);
`endif

        // Random traffic against the model
        for (int c = 0; c < 300; c++) begin
            req       = NR'($urandom_range(0, 15));
            seed_load = ($urandom_range(0, 15) == 0);
            lfsr_seed = 8'($urandom_range(0, 255));
            lock      = ($urandom_range(0, 3) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            step();
            check_eq("rnd_onehot", 32'($countones(grant) <= 1), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
